baudot5_frame_rx: RTL and testbench
===================================

# baudot5_frame_rx

Serial frame receiver for the 5-bit shift-register transmitter already in this design. It samples one line bit per clock (same clock as the transmitter), hunts for a start bit, shifts in 5 data bits LSB-first, checks the fixed 3-bit marker and stop bit, and presents the decoded code word with a one-cycle valid pulse. It sits between a serial input pin and any downstream consumer of the decoded 5-bit characters.

## Interface

Parameters:
- DATA_BITS, 5, number of payload bits per frame, LSB first.
- MARKER, 3'b010, fixed marker after the data, transmitted MSB first (line order 0,1,0).

Ports:
- clk  input  1  system clock; one line bit per rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  clock enable; 0 freezes all state.
- rx  input  1  serial line, idle high, asynchronous to nothing but still synchronized (pin-sourced).
- data  output  DATA_BITS  last good code word; d0 in bit 0.
- valid  output  1  one-cycle pulse: data just updated.
- frame_err  output  1  one-cycle pulse: frame rejected.
- busy  output  1  high whenever FSM is not in IDLE.
- frame_count  output  8  count of good frames, wraps 255 -> 0.

## Operation

- Frame on line, in order: start 0, d0..d(DATA_BITS-1), MARKER bits 0,1,0, stop 1 (10 bits at default). Any number of idle 1s may separate frames; zero idle bits (next start immediately after stop) must be accepted.
- rx passes through a 2-flop synchronizer (rx_s); FSM uses rx_s only.
- States:
  - IDLE: rx_s=0 -> DATA, bit counter 0. rx_s=1 -> stay.
  - DATA: shift rx_s into shift register (LSB-first: new bit enters MSB, register shifts right); after DATA_BITS samples -> MARK, counter 0.
  - MARK: compare rx_s to MARKER bit (MSB first); OR any mismatch into sticky bad flag; after 3 samples -> STOP.
  - STOP: if rx_s=1 and bad=0: load data, pulse valid, frame_count+1. Else pulse frame_err, data unchanged. Always -> IDLE, bad cleared.
- A stop-bit value of 0 is not treated as a new start bit; IDLE re-examines the next sample.
- valid and frame_err never assert in the same cycle.
- ena=0: synchronizer, FSM, counters, data all hold; valid and frame_err forced 0 that cycle. Resuming ena continues exactly where it stopped.
- Reset (any time, including mid-frame): state IDLE, synchronizer flops 1 (idle line), shift register 0, data 0, valid 0, frame_err 0, busy 0, frame_count 0. Partial frame is discarded, no error pulse.

## Timing

- Bit i of a frame (start = bit 0) captured into sync flop 1 at edge T+i; FSM samples it at edge T+i+2.
- Start captured at T: state leaves IDLE at T+2; busy high from T+2.
- Stop captured at edge S = T+DATA_BITS+4: valid or frame_err high for exactly cycle [S+2, S+3); data and frame_count change at S+2; busy low from S+2.
- Back-to-back frames: next start captured at S+1 is sampled at S+3 in IDLE; no bit lost.
- Throughput: one frame per DATA_BITS+5 clocks maximum.
- All outputs registered; no combinational path rx -> outputs.

## Test plan

- Single frame, data 5'b10110: after reset and 4 idle 1s drive 0,0,1,1,0,1,0,1,0,1 then 1s -> valid one cycle exactly 2 clocks after stop capture, data=5'b10110, frame_count=1, frame_err never high.
- Bad marker: same frame with marker 0,0,0 -> frame_err one cycle at same position, data stays 5'b00000, frame_count=0; following good frame 5'b00001 accepted.
- Bad stop: stop bit 0 then line idles high -> frame_err pulse, FSM in IDLE, no spurious frame from the 0 stop bit.
- Continuous transmitter loop (4 ones + frame 5'b11111 + 4 ones, repeated 300 frames, plus zero-gap back-to-back run) -> 300 valid pulses, frame_count=300 mod 256=44, no errors.
- Reset mid-frame after d2, then clean frame 5'b01010 -> no pulse for the aborted frame, outputs at reset values, then valid with data=5'b01010.
- ena low for 3 cycles in middle of data bits with rx held constant and resumed -> frame decoded correctly, valid delayed by exactly 3 cycles.

Source files
------------

// File: rtl/baudot5_frame_rx.sv
// Serial frame receiver: start bit, LSB-first payload, fixed 3-bit marker, stop bit.
// Pin input is double-synchronized; all outputs come straight from flops.
module baudot5_frame_rx #(
  parameter int           DATA_BITS = 5,
  parameter logic [2:0]   MARKER    = 3'b010
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic [7:0]           frame_count
);

  // state | meaning
  // IDLE  | hunting for a start bit (rx_s == 0)
  // DATA  | shifting in DATA_BITS payload bits, LSB first
  // MARK  | comparing three marker bits, MSB first, into a sticky bad flag
  // STOP  | judging stop bit and bad flag, emitting valid or frame_err
  typedef enum logic [1:0] {IDLE, DATA, MARK, STOP} state_t;

  localparam logic [7:0] LAST_DATA = 8'(DATA_BITS - 1);

  state_t               state;
  logic                 rx_m;
  logic                 rx_s;
  logic [DATA_BITS-1:0] shreg;
  logic [7:0]           cnt;
  logic                 bad;
  logic                 mark_bit;

  always_comb begin
    mark_bit = MARKER[0];
    case (cnt[1:0])
      2'd0:    mark_bit = MARKER[2];
      2'd1:    mark_bit = MARKER[1];
      default: mark_bit = MARKER[0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      bad         <= 1'b0;
      data        <= '0;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
    end else if (!ena) begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= DATA;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        DATA: begin
          shreg <= {rx_s, shreg[DATA_BITS-1:1]};
          if (cnt == LAST_DATA) begin
            state <= MARK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        MARK: begin
          bad <= bad | (rx_s != mark_bit);
          if (cnt == 8'd2) state <= STOP;
          else             cnt   <= cnt + 8'd1;
        end
        STOP: begin
          // A low stop bit is only an error; IDLE looks at the next sample afresh.
          if (rx_s && !bad) begin
            data        <= shreg;
            valid       <= 1'b1;
            frame_count <= frame_count + 8'd1;
          end else begin
            frame_err <= 1'b1;
          end
          bad   <= 1'b0;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_baudot5_frame_rx.sv
// Scoreboard bench for baudot5_frame_rx: frames push expected pulses, a negedge
// monitor pops and compares them against what the receiver presents.
module tb_baudot5_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       rx = 1'b1;
  logic [4:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic [7:0] frame_count;

  baudot5_frame_rx #(.DATA_BITS(5), .MARKER(3'b010)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx),
    .data(data), .valid(valid), .frame_err(frame_err),
    .busy(busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [4:0] d;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [4:0] m_data = '0;
  logic [7:0] m_cnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (valid || frame_err)) begin
      chk("valid_and_err_exclusive", int'(valid && frame_err), 0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind_err", int'(frame_err), int'(e.err));
        chk("pulse_data", int'(data), int'(e.d));
        chk("pulse_count", int'(frame_count), int'(e.cnt));
        chk("pulse_cycle", cyc, e.cyc);
        chk("busy_at_pulse", int'(busy), 0);
      end
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  // gap_at: line-bit index after whose capture ena drops for gap_len edges.
  task automatic send_frame(input logic [4:0] d, input logic [2:0] mk,
                            input logic stop, input int gap_at, input int gap_len);
    logic [9:0] bits;
    int         t0;
    exp_t       e;
    bits = {stop, mk[0], mk[1], mk[2], d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      send_bit(bits[i]);
      if (i == 0) begin
        t0 = cyc;
        e.err = !((mk == 3'b010) && stop);
        if (!e.err) begin
          m_data = d;
          m_cnt  = m_cnt + 8'd1;
        end
        e.d   = m_data;
        e.cnt = m_cnt;
        e.cyc = t0 + 11 + ((gap_at >= 0) ? gap_len : 0);
        sb.push_back(e);
      end
      if (i == 1) chk("busy_low_T+1", int'(busy), 0);
      if (i == 2) chk("busy_high_T+2", int'(busy), 1);
      if (i == gap_at) begin
        ena = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
        ena = 1'b1;
      end
    end
  endtask

  task automatic drain(input string name);
    rx = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk(name, sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, int'(data), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_err"}, int'(frame_err), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_count"}, int'(frame_count), 0);
  endtask

  task automatic do_reset(input string tag);
    rx = 1'b1;
    rst_n = 1'b0;
    #2;
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_data = '0;
    m_cnt  = '0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    idle(4);

    // Single good frame 5'b10110: line 0,0,1,1,0,1,0,1,0,1.
    send_frame(5'b10110, 3'b010, 1'b1, -1, 0);
    idle(4);
    drain("drain_single");
    chk("single_data", int'(data), 'b10110);
    chk("single_count", int'(frame_count), 1);

    // Bad marker from reset, then a good 5'b00001.
    do_reset("rst_a");
    idle(4);
    send_frame(5'b10110, 3'b000, 1'b1, -1, 0);
    idle(4);
    drain("drain_badmark");
    chk("badmark_data", int'(data), 0);
    chk("badmark_count", int'(frame_count), 0);
    send_frame(5'b00001, 3'b010, 1'b1, -1, 0);
    idle(4);
    drain("drain_after_badmark");
    chk("after_badmark_data", int'(data), 1);

    // Bad stop bit followed by idle line: one error, no phantom frame.
    send_frame(5'b00110, 3'b010, 1'b0, -1, 0);
    idle(14);
    drain("drain_badstop");
    chk("badstop_busy", int'(busy), 0);
    chk("badstop_count", int'(frame_count), 1);

    // Reset after d2 of a partial frame, then a clean 5'b01010.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    do_reset("rst_mid");
    idle(4);
    send_frame(5'b01010, 3'b010, 1'b1, -1, 0);
    idle(4);
    drain("drain_after_rst");
    chk("after_rst_data", int'(data), 'b01010);
    chk("after_rst_count", int'(frame_count), 1);

    // ena low for 3 edges after d1; pulse expected 3 cycles later.
    send_frame(5'b11001, 3'b010, 1'b1, 2, 3);
    idle(4);
    drain("drain_ena_gap");
    chk("ena_gap_data", int'(data), 'b11001);

    // 280 gapped frames plus 20 back-to-back: 300 frames total.
    do_reset("rst_loop");
    for (int f = 0; f < 280; f++) begin
      idle(4);
      send_frame(5'b11111, 3'b010, 1'b1, -1, 0);
      idle(4);
    end
    for (int f = 0; f < 20; f++) send_frame(5'b11111, 3'b010, 1'b1, -1, 0);
    idle(4);
    drain("drain_loop");
    chk("loop_count", int'(frame_count), 44);
    chk("loop_data", int'(data), 'b11111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
